// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the scanning 7-segment driver:
//   - 7-bit glyph constants, segment order {a,b,c,d,e,f,g} with a in bit 6
//   - scan state encoding used by seg7_scan_driver
// The optional hex glyphs (SEG_A..SEG_F) are selected by the encoder only when
// the HEX_GLYPHS_EN macro is defined.
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage : seg7_pkg

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundle between the score/timer logic (master) and the scan driver (slave).
//   enable        master -> slave  1 = scan running, 0 = display dark
//   digits_in     master -> slave  nibble k = value for digit k
//   dp_in         master -> slave  bit k = decimal point for digit k
//   seven_segment slave -> master  {a,b,c,d,e,f,g,dp}, active-high
//   control       slave -> master  digit enables, active-low
//   frame_tick    slave -> master  pulse on each shadow capture
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [7:0]                seven_segment;
  logic [NUM_DIGITS-1:0]     control;
  logic                      frame_tick;

  modport master (
    output enable, digits_in, dp_in,
    input  seven_segment, control, frame_tick
  );

  modport slave (
    input  enable, digits_in, dp_in,
    output seven_segment, control, frame_tick
  );

endinterface : seg7_scan_driver_if

// File: rtl/seg7_glyph_encode.sv
// -----------------------------------------------------------------------------
// seg7_glyph_encode
// Combinational nibble -> 7-bit glyph {a..g}.
//   i_nibble  4-bit digit code
//   o_glyph   7-bit segment pattern, active-high, a in bit 6
// Codes A-F render as hex letters only when HEX_GLYPHS_EN is defined;
// otherwise they render blank.
// -----------------------------------------------------------------------------
module seg7_glyph_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  // Glyph lookup; unlisted codes fall through to blank
  always_comb begin
    o_glyph = SEG_OFF;
    case (i_nibble)
      4'h0:    o_glyph = SEG_0;
      4'h1:    o_glyph = SEG_1;
      4'h2:    o_glyph = SEG_2;
      4'h3:    o_glyph = SEG_3;
      4'h4:    o_glyph = SEG_4;
      4'h5:    o_glyph = SEG_5;
      4'h6:    o_glyph = SEG_6;
      4'h7:    o_glyph = SEG_7;
      4'h8:    o_glyph = SEG_8;
      4'h9:    o_glyph = SEG_9;
`ifdef HEX_GLYPHS_EN
      4'hA:    o_glyph = SEG_A;
      4'hB:    o_glyph = SEG_B;
      4'hC:    o_glyph = SEG_C;
      4'hD:    o_glyph = SEG_D;
      4'hE:    o_glyph = SEG_E;
      4'hF:    o_glyph = SEG_F;
`endif
      default: o_glyph = SEG_OFF;
    endcase
  end

endmodule : seg7_glyph_encode

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit 7-segment bank. Each digit slot is
// SCAN_DIV clocks: BLANK_CYCLES dark (anti-ghosting), then driven. The digit
// and decimal-point buses are shadowed once per frame so mid-frame updates
// never tear the display.
//   clk    system clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    seg7_scan_driver_if.slave (enable, digits_in, dp_in in;
//          seven_segment, control, frame_tick out, all registered)
// Optional build macro: HEX_GLYPHS_EN (hex letters for codes A-F).
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_driver_if.slave    bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] C_SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_e               r_state;
  logic [CW-1:0]             r_count;
  logic [IW-1:0]             r_index;
  logic [4*NUM_DIGITS-1:0]   r_shadow_digits;
  logic [NUM_DIGITS-1:0]     r_shadow_dp;
  logic [7:0]                r_seg;
  logic [NUM_DIGITS-1:0]     r_control;
  logic                      r_frame_tick;

  logic [3:0]                w_nibble;
  logic                      w_dp;
  logic [NUM_DIGITS-1:0]     w_onecold;
  logic [6:0]                w_glyph;

  // Select the current digit's shadow nibble/dp and build its one-cold enable
  always_comb begin
    w_nibble  = 4'h0;
    w_dp      = 1'b0;
    w_onecold = {NUM_DIGITS{1'b1}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_index == IW'(k)) begin
        w_nibble     = r_shadow_digits[4*k +: 4];
        w_dp         = r_shadow_dp[k];
        w_onecold[k] = 1'b0;
      end else begin
        w_onecold[k] = 1'b1;
      end
    end
  end

  seg7_glyph_encode u_glyph (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  // Scan FSM; pins are registered from the pre-edge state, so they trail the
  // state register by one clock, except enable=0 which darkens on the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_count         <= {CW{1'b0}};
      r_index         <= {IW{1'b0}};
      r_shadow_digits <= {(4*NUM_DIGITS){1'b0}};
      r_shadow_dp     <= {NUM_DIGITS{1'b0}};
      r_seg           <= 8'h00;
      r_control       <= {NUM_DIGITS{1'b1}};
      r_frame_tick    <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (!bus.enable) begin
        // Shadow is deliberately kept so re-enable does not flash stale zeros
        r_state   <= IDLE;
        r_count   <= {CW{1'b0}};
        r_index   <= {IW{1'b0}};
        r_seg     <= 8'h00;
        r_control <= {NUM_DIGITS{1'b1}};
      end else begin
        case (r_state)
          IDLE: begin
            r_state         <= BLANK;
            r_count         <= {CW{1'b0}};
            r_index         <= {IW{1'b0}};
            r_shadow_digits <= bus.digits_in;
            r_shadow_dp     <= bus.dp_in;
            r_frame_tick    <= 1'b1;
            r_seg           <= 8'h00;
            r_control       <= {NUM_DIGITS{1'b1}};
          end
          BLANK: begin
            r_seg     <= 8'h00;
            r_control <= {NUM_DIGITS{1'b1}};
            r_count   <= r_count + CW'(1);
            if (r_count == C_BLANK_LAST) begin
              r_state <= DRIVE;
            end else begin
              r_state <= BLANK;
            end
          end
          DRIVE: begin
            r_seg     <= {w_glyph, w_dp};
            r_control <= w_onecold;
            if (r_count == C_SLOT_LAST) begin
              r_count <= {CW{1'b0}};
              r_state <= BLANK;
              if (r_index == C_IDX_LAST) begin
                // Frame boundary: latch the next frame's digits
                r_index         <= {IW{1'b0}};
                r_shadow_digits <= bus.digits_in;
                r_shadow_dp     <= bus.dp_in;
                r_frame_tick    <= 1'b1;
              end else begin
                r_index <= r_index + IW'(1);
              end
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
          default: begin
            r_state   <= IDLE;
            r_count   <= {CW{1'b0}};
            r_index   <= {IW{1'b0}};
            r_seg     <= 8'h00;
            r_control <= {NUM_DIGITS{1'b1}};
          end
        endcase
      end
    end
  end

  assign bus.seven_segment = r_seg;
  assign bus.control       = r_control;
  assign bus.frame_tick    = r_frame_tick;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2. Expected pins per edge come from the slot timing:
// n edges after the capture edge, the pins show slot cycle (n-1)%8 of digit
// ((n-1)/8)%4 -- dark for cycles 0..1, glyph afterwards -- and frame_tick is
// high when n is a multiple of 32. Glyphs are hand-entered constants.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * SD;

  logic clk;
  logic rst_n;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_vectors    = 0;
  int         n_miscompares = 0;
  int         n_edge       = 0;
  logic [7:0] exp_glyph [ND];

  function automatic logic [7:0] tb_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'b11111100;
      4'h1: return 8'b01100000;
      4'h2: return 8'b11011010;
      4'h3: return 8'b11110010;
      4'h4: return 8'b01100110;
      4'h5: return 8'b10110110;
      4'h6: return 8'b10111110;
      4'h7: return 8'b11100000;
      4'h8: return 8'b11111110;
      4'h9: return 8'b11110110;
`ifdef HEX_GLYPHS_EN
      4'hA: return 8'b11101110;
      4'hB: return 8'b00111110;
      4'hC: return 8'b10011100;
      4'hD: return 8'b01111010;
      4'hE: return 8'b10011110;
      4'hF: return 8'b10001110;
`endif
      default: return 8'b00000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] es,
                       input logic [3:0] ec, input logic ef);
    logic [12:0] obs;
    logic [12:0] expv;
    obs  = {bus.seven_segment, bus.control, bus.frame_tick};
    expv = {es, ec, ef};
    n_vectors++;
    assert (obs === expv) else begin
      n_miscompares++;
      $error("FAIL %s edge=%0d: observed seg=%b ctl=%b ft=%b, expected seg=%b ctl=%b ft=%b",
             tag, n_edge, obs[12:5], obs[4:1], obs[0], es, ec, ef);
    end
  endtask

  // Model of what the DUT latched from the bus at a capture edge
  task automatic capture();
    logic [7:0] g;
    for (int k = 0; k < ND; k++) begin
      g    = tb_glyph(bus.digits_in[4*k +: 4]);
      g[0] = bus.dp_in[k];
      exp_glyph[k] = g;
    end
  endtask

  // Edge leaving IDLE with enable high: dark pins, frame_tick, fresh capture
  task automatic start_edge(input string tag);
    @(posedge clk); #1;
    n_edge = 0;
    check(tag, 8'h00, 4'hF, 1'b1);
    capture();
  endtask

  // One scanning edge checked against the slot timing model
  task automatic step(input string tag);
    int c;
    int d;
    logic [7:0] es;
    logic [3:0] ec;
    logic       ef;
    @(posedge clk); #1;
    n_edge++;
    c  = (n_edge - 1) % SD;
    d  = ((n_edge - 1) / SD) % ND;
    ec = 4'hF;
    if (c < BC) begin
      es = 8'h00;
    end else begin
      es    = exp_glyph[d];
      ec[d] = 1'b0;
    end
    ef = ((n_edge % FRAME) == 0);
    check(tag, es, ec, ef);
    if (ef) capture();
  endtask

  task automatic step_dark(input string tag);
    @(posedge clk); #1;
    check(tag, 8'h00, 4'hF, 1'b0);
  endtask

  task automatic run_to(input string tag, input int target);
    while (n_edge < target) step(tag);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.enable    = 1'b0;
    bus.digits_in = 16'h0000;
    bus.dp_in     = 4'b0000;
    #1 rst_n = 1'b0;
    #2 check("reset", 8'h00, 4'hF, 1'b0);
    step_dark("reset_held");
    step_dark("reset_held");

    // 1: basic scan of 4321
    rst_n         = 1'b1;
    bus.enable    = 1'b1;
    bus.digits_in = 16'h4321;
    bus.dp_in     = 4'b0000;
    start_edge("first_capture");
    run_to("scan_4321", 2 * FRAME);

    // 2: mid-frame update during digit 1 slot must not tear
    run_to("scan_4321", 2 * FRAME + 12);
    bus.digits_in = 16'h9999;
    run_to("no_tear", 4 * FRAME);

    // 3: decimal point on digit 2 only
    run_to("scan_9999", 4 * FRAME + 5);
    bus.digits_in = 16'h0000;
    bus.dp_in     = 4'b0100;
    run_to("dp_digit2", 6 * FRAME);

    // 4: hex codes, blank unless hex glyphs are built in
    bus.digits_in = 16'hABCD;
    bus.dp_in     = 4'b0000;
    run_to("hex_abcd", 8 * FRAME + 20);

    // 5: enable dropped in a DRIVE slot, then re-asserted
    bus.enable = 1'b0;
    step_dark("enable_off");
    step_dark("enable_off");
    step_dark("enable_off");
    bus.digits_in = 16'h5678;
    bus.dp_in     = 4'b0001;
    bus.enable    = 1'b1;
    start_edge("reenable_capture");
    run_to("reenable_scan", FRAME + 20);

    // 6: asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1 check("async_reset", 8'h00, 4'hF, 1'b0);
    step_dark("reset_mid");
    step_dark("reset_mid");
    rst_n = 1'b1;
    start_edge("post_reset_capture");
    run_to("post_reset_scan", FRAME + 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_seg7_scan_driver
